divisor_sequencer: RTL
======================

DIVISOR_SEQUENCER -- requirements
Module: divisor_sequencer

Interface
REQ-001 The block SHALL have parameter NSLOT, default 4, giving the number of sequence slots (power of two, 2..16).
REQ-002 The block SHALL have parameter DW, default 27, giving the divisor width.
REQ-003 The block SHALL have parameter HW, default 8, giving the hold-count width.
REQ-004 CLK  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 cfg_we  input  1  slot-table write strobe.
REQ-007 cfg_addr  input  log2(NSLOT)  slot index written.
REQ-008 cfg_divisor  input  DW  divisor stored to slot.
REQ-009 cfg_hold  input  HW  tick rising edges per slot.
REQ-010 start  input  1  begin sequence at slot 0 (level, sampled).
REQ-011 stop  input  1  abort sequence.
REQ-012 loop  input  1  1 = wrap to slot 0 after last slot; 0 = one pass.
REQ-013 tick  input  1  divided clock fed back from the converter (CLK-synchronous).
REQ-014 divisor  output  DW  divisor driven to the converter, registered.
REQ-015 conv_reset  output  1  active-high converter reset, registered.
REQ-016 slot  output  log2(NSLOT)  current slot index.
REQ-017 busy  output  1  high in LOAD and RUN.
REQ-018 done  output  1  one-cycle pulse when a one-pass sequence completes.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, RUN and DONE.
REQ-020 IDLE: conv_reset=1, busy=0; start=1 and stop=0 -> LOAD with slot=0.
REQ-021 LOAD, one cycle: divisor=max(table_div[slot],1), conv_reset=1, edge count cleared, tick history cleared to 0 -> RUN.
REQ-022 RUN: conv_reset=0; tick rising edge = tick & ~tick_d, with tick_d registered each cycle.
REQ-023 Hold target SHALL be table_hold[slot], with a value of 0 meaning 2^HW.
REQ-024 On the edge that brings the count to the hold target, a non-last slot SHALL go to LOAD with slot+1.
REQ-025 On the hold target at slot NSLOT-1, loop=1 -> LOAD with slot=0; loop=0 -> DONE.
REQ-026 DONE, one cycle: done=1, conv_reset=1, busy=0 -> IDLE; slot holds its last value.
REQ-027 stop=1 in any state SHALL force IDLE on the next edge, with conv_reset=1 and no done pulse; stop SHALL win over start in the same cycle.
REQ-028 start while busy SHALL be ignored.
REQ-029 cfg_we SHALL write the table in any state; a write to the active slot SHALL take effect only at that slot's next LOAD (divisor is latched at LOAD).
REQ-030 A write to a slot in the same cycle as its LOAD SHALL make LOAD use the old value.
REQ-031 Latency: start is sampled at edge t; LOAD outputs are visible after t; conv_reset deasserts after t+1.
REQ-032 The edge counter SHALL be HW+1 bits wide with no overflow; the slot index SHALL wrap modulo NSLOT only via REQ-025.

Reset
REQ-033 While reset=0: state=IDLE, divisor=1, conv_reset=1, slot=0, busy=0, done=0, tick_d=0, count=0.
REQ-034 While reset=0: every table_div entry SHALL be 1 and every table_hold entry SHALL be 1.
REQ-035 Reset deassertion mid-sequence SHALL resume in IDLE only; no sequence state SHALL be retained.

Verification
REQ-036 Program slot0 div=2 hold=3, slots 1..3 div=1 hold=1, loop=0; pulse start -> slot0 RUN lasts 3 tick edges (12 CLK with a divide-by-2 converter), slots 1..3 follow, then done pulses exactly once and busy=0.
REQ-037 Same table with loop=1 -> after slot 3, slot returns to 0 with divisor=2; no done pulse over 3 full passes.
REQ-038 In RUN at slot 1, assert stop together with start -> next cycle IDLE, conv_reset=1, busy=0, no done.
REQ-039 Program slot2 div=0 hold=0 -> in slot 2, divisor=1 and RUN lasts 256 tick edges.
REQ-040 During slot 0 RUN, write slot0 div=5 -> divisor stays 2 until the next slot-0 LOAD (loop=1), then reads 5.
REQ-041 Drop reset to 0 in RUN at slot 2 -> outputs immediately show their reset values, table reads back 1/1, and start is required to restart.

Source files
------------

// File: rtl/divisor_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : divisor_sequencer_if
//  Purpose  : Slot-table configuration, sequence control and converter-facing
//             signals of the divisor sequencer, bundled as one interface.
//  Revision : 1.0 - initial release
// ============================================================================
interface divisor_sequencer_if #(
  parameter int NSLOT = 4,
  parameter int DW    = 27,
  parameter int HW    = 8
);
  localparam int c_SW = $clog2(NSLOT);

  // Slot-table write port
  logic            cfg_we;
  logic [c_SW-1:0] cfg_addr;
  logic [DW-1:0]   cfg_divisor;
  logic [HW-1:0]   cfg_hold;

  // Sequence control and divided-clock feedback
  logic            start;
  logic            stop;
  logic            loop;
  logic            tick;

  // Sequencer outputs
  logic [DW-1:0]   divisor;
  logic            conv_reset;
  logic [c_SW-1:0] slot;
  logic            busy;
  logic            done;

  modport master (
    output cfg_we, cfg_addr, cfg_divisor, cfg_hold, start, stop, loop, tick,
    input  divisor, conv_reset, slot, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_divisor, cfg_hold, start, stop, loop, tick,
    output divisor, conv_reset, slot, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/divisor_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : divisor_sequencer
//  Purpose  : Steps a clock converter through a table of (divisor, hold)
//             slots. Each slot is held for a number of rising edges of the
//             converter's divided tick, then the next slot is loaded.
//  Revision : 1.0 - initial release
// ============================================================================
module divisor_sequencer #(
  parameter int NSLOT = 4,
  parameter int DW    = 27,
  parameter int HW    = 8
) (
  input wire                 CLK,
  input wire                 reset,
  divisor_sequencer_if.slave bus
);

  localparam int              c_SW   = $clog2(NSLOT);
  localparam logic [c_SW-1:0] c_LAST = c_SW'(NSLOT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  logic [DW-1:0]   r_tab_div  [NSLOT];
  logic [HW-1:0]   r_tab_hold [NSLOT];

  state_t          r_state;
  logic [DW-1:0]   r_divisor;
  logic            r_conv_reset;
  logic [c_SW-1:0] r_slot;
  logic            r_busy;
  logic            r_done;
  logic            r_tick_d;
  logic [HW:0]     r_count;
  logic [HW:0]     r_hold_tgt;

  logic [c_SW-1:0] w_load_slot;
  logic [DW-1:0]   w_load_div;
  logic [HW:0]     w_load_hold;
  logic            w_last;
  logic            w_tick_rise;
  logic [HW:0]     w_count_inc;
  logic            w_hit;

  // Slot table: writable in any state; reads at LOAD entry see pre-write data
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        r_tab_div[i]  <= DW'(1);
        r_tab_hold[i] <= HW'(1);
      end
    end else if (bus.cfg_we) begin
      r_tab_div[bus.cfg_addr]  <= bus.cfg_divisor;
      r_tab_hold[bus.cfg_addr] <= bus.cfg_hold;
    end
  end

  // Slot to be loaded next: 0 from IDLE or after the last slot, else slot+1
  always_comb begin
    w_load_slot = '0;
    if (r_state == S_RUN && !w_last) begin
      w_load_slot = r_slot + 1'b1;
    end
  end

  assign w_last      = (r_slot == c_LAST);
  // A zero divisor is clamped to 1; a zero hold means the full 2^HW edges
  assign w_load_div  = (r_tab_div[w_load_slot] == '0) ? DW'(1) : r_tab_div[w_load_slot];
  assign w_load_hold = {(r_tab_hold[w_load_slot] == '0), r_tab_hold[w_load_slot]};
  assign w_tick_rise = bus.tick & ~r_tick_d;
  assign w_count_inc = r_count + 1'b1;
  assign w_hit       = w_tick_rise && (w_count_inc == r_hold_tgt);

  // Sequencer FSM with registered outputs; stop overrides everything
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_divisor    <= DW'(1);
      r_conv_reset <= 1'b1;
      r_slot       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_tick_d     <= 1'b0;
      r_count      <= '0;
      r_hold_tgt   <= {{HW{1'b0}}, 1'b1};
    end else begin
      r_done <= 1'b0;
      if (bus.stop) begin
        r_state      <= S_IDLE;
        r_conv_reset <= 1'b1;
        r_busy       <= 1'b0;
        r_tick_d     <= 1'b0;
        r_count      <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_conv_reset <= 1'b1;
            r_busy       <= 1'b0;
            if (bus.start) begin
              r_state    <= S_LOAD;
              r_slot     <= '0;
              r_divisor  <= w_load_div;
              r_hold_tgt <= w_load_hold;
              r_busy     <= 1'b1;
            end
          end
          S_LOAD: begin
            r_state      <= S_RUN;
            r_conv_reset <= 1'b0;
            r_count      <= '0;
            r_tick_d     <= 1'b0;
          end
          S_RUN: begin
            r_tick_d <= bus.tick;
            if (w_tick_rise) begin
              r_count <= w_count_inc;
            end
            if (w_hit) begin
              r_conv_reset <= 1'b1;
              if (!w_last || bus.loop) begin
                r_state    <= S_LOAD;
                r_slot     <= w_load_slot;
                r_divisor  <= w_load_div;
                r_hold_tgt <= w_load_hold;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end
          end
          S_DONE: begin
            r_state      <= S_IDLE;
            r_conv_reset <= 1'b1;
            r_busy       <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.divisor    = r_divisor;
  assign bus.conv_reset = r_conv_reset;
  assign bus.slot       = r_slot;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
`default_nettype wire
